// File: rtl/harvos_satp_mode_guard.sv
// harvos_satp_mode_guard: runtime checker for the satp CSR.
// Flags illegal translation modes (edge-triggered) and satp writes that are not
// followed by an sfence.vma within a bounded window. Reports registered pulses,
// sticky status, a saturating event count and first-violation capture.
module harvos_satp_mode_guard #(
  parameter int unsigned XLEN          = 32,
  parameter logic [15:0] ALLOWED_MODES = 16'h0002,
  parameter int unsigned GRACE_CYCLES  = 4,
  parameter int unsigned SFENCE_WINDOW = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [XLEN-1:0]  csr_satp_q,
  input  logic             csr_satp_we,
  input  logic             sfence_vma_valid,
  input  logic             viol_clr,
  output logic             viol_pulse,
  output logic [1:0]       viol_code,
  output logic             viol_sticky,
  output logic [CNT_W-1:0] viol_count,
  output logic [XLEN-1:0]  first_satp,
  output logic [1:0]       first_code
);

  localparam int unsigned TMR_W    = (SFENCE_WINDOW > 1) ? $clog2(SFENCE_WINDOW) : 1;
  localparam int unsigned GRC_W    = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam int unsigned TMR_LAST = (SFENCE_WINDOW > 0) ? SFENCE_WINDOW - 1 : 0;
  localparam int unsigned GRC_LAST = (GRACE_CYCLES > 0) ? GRACE_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_GRACE   = 2'd0,
    ST_MONITOR = 2'd1,
    ST_AWAIT   = 2'd2
  } state_e;

  localparam state_e RST_STATE = (GRACE_CYCLES == 0) ? ST_MONITOR : ST_GRACE;

  // Reject unsupported configurations at elaboration
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("harvos_satp_mode_guard: XLEN must be 32 or 64");
  end
  if (SFENCE_WINDOW < 1) begin : g_bad_window
    $error("harvos_satp_mode_guard: SFENCE_WINDOW must be at least 1");
  end

  // MODE field extraction: RV32 has a 1-bit MODE, RV64 a 4-bit one
  logic [3:0] mode;
  if (XLEN == 64) begin : g_mode64
    assign mode = csr_satp_q[XLEN-1 -: 4];
  end else begin : g_mode32
    assign mode = {3'b000, csr_satp_q[XLEN-1]};
  end

  logic illegal;
  assign illegal = ~ALLOWED_MODES[mode];

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [GRC_W-1:0]   grace_q, grace_d;
  logic               illegal_q, illegal_d;
  logic               viol_pulse_q, viol_pulse_d;
  logic [1:0]         viol_code_q, viol_code_d;
  logic               viol_sticky_q, viol_sticky_d;
  logic [CNT_W-1:0]   viol_count_q, viol_count_d;
  logic [XLEN-1:0]    first_satp_q, first_satp_d;
  logic [1:0]         first_code_q, first_code_d;
  logic               ill_evt, to_evt;
  logic [1:0]         evt_code;

  // FSM state, window timer and grace counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      timer_q <= '0;
      grace_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      grace_q <= grace_d;
    end
  end

  // Next-state: grace countdown, then satp-write / sfence window tracking
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    grace_d = grace_q;
    unique case (state_q)
      ST_GRACE: begin
        if (grace_q == GRC_W'(GRC_LAST)) begin
          state_d = ST_MONITOR;
          grace_d = '0;
        end else begin
          grace_d = grace_q + GRC_W'(1);
        end
      end
      ST_MONITOR: begin
        if (enable && csr_satp_we) begin
          state_d = ST_AWAIT;
          timer_d = '0;
        end
      end
      ST_AWAIT: begin
        if (!enable) begin
          state_d = ST_MONITOR;
          timer_d = '0;
        end else if (sfence_vma_valid) begin
          state_d = ST_MONITOR;
          timer_d = '0;
        end else if (csr_satp_we) begin
          timer_d = '0;
        end else if (timer_q == TMR_W'(TMR_LAST)) begin
          state_d = ST_MONITOR;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_MONITOR;
        timer_d = '0;
      end
    endcase
  end

  // Event detection and next values of the reported status
  always_comb begin
    illegal_d     = 1'b0;
    ill_evt       = 1'b0;
    to_evt        = 1'b0;
    viol_sticky_d = viol_sticky_q;
    viol_count_d  = viol_count_q;
    first_satp_d  = first_satp_q;
    first_code_d  = first_code_q;
    if (enable && (state_q != ST_GRACE)) begin
      illegal_d = illegal;
      ill_evt   = illegal & ~illegal_q;
      to_evt    = (state_q == ST_AWAIT) & ~sfence_vma_valid & ~csr_satp_we &
                  (timer_q == TMR_W'(TMR_LAST));
    end
    evt_code     = {to_evt, ill_evt};
    viol_pulse_d = |evt_code;
    viol_code_d  = evt_code;
    if (viol_pulse_d) begin
      // A new event overrides a same-cycle clear
      viol_sticky_d = 1'b1;
      if (viol_clr) begin
        viol_count_d = CNT_W'(1);
      end else if (!(&viol_count_q)) begin
        viol_count_d = viol_count_q + CNT_W'(1);
      end
      if (!viol_sticky_q || viol_clr) begin
        first_satp_d = csr_satp_q;
        first_code_d = evt_code;
      end
    end else if (viol_clr) begin
      viol_sticky_d = 1'b0;
      viol_count_d  = '0;
      first_satp_d  = '0;
      first_code_d  = 2'b00;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q     <= 1'b0;
      viol_pulse_q  <= 1'b0;
      viol_code_q   <= 2'b00;
      viol_sticky_q <= 1'b0;
      viol_count_q  <= '0;
      first_satp_q  <= '0;
      first_code_q  <= 2'b00;
    end else begin
      illegal_q     <= illegal_d;
      viol_pulse_q  <= viol_pulse_d;
      viol_code_q   <= viol_code_d;
      viol_sticky_q <= viol_sticky_d;
      viol_count_q  <= viol_count_d;
      first_satp_q  <= first_satp_d;
      first_code_q  <= first_code_d;
    end
  end

  assign viol_pulse  = viol_pulse_q;
  assign viol_code   = viol_code_q;
  assign viol_sticky = viol_sticky_q;
  assign viol_count  = viol_count_q;
  assign first_satp  = first_satp_q;
  assign first_code  = first_code_q;

endmodule
